// File: rtl/umi_pkg.sv
`default_nettype none
//============================================================================
// Package : umi_pkg
// Desc    : Shared UMI command-field constants and decode helpers.
// Rev     : 1.0 - initial release
//============================================================================
package umi_pkg;

  // Request opcodes carried in cmd[4:0]
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] REQ_ATOMIC = 5'h09;

  // Command field positions
  localparam int UMI_EOM_BIT    = 22;
  localparam int UMI_OPCODE_LSB = 0;
  localparam int UMI_OPCODE_W   = 5;

  // Arbiter message-lock state
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // True for opcodes whose completion comes back through the response channel
  function automatic logic umi_is_rb(input logic [4:0] opcode);
    case (opcode)
      REQ_READ, REQ_WRITE, REQ_ATOMIC: umi_is_rb = 1'b1;
      REQ_POSTED:                      umi_is_rb = 1'b0;
      default:                         umi_is_rb = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/umi_arb_tagfifo.sv
`default_nettype none
//============================================================================
// Module : umi_arb_tagfifo
// Desc   : Synchronous FIFO of requester indices; the head names the port
//          that owns the next in-order response from the memory agent.
// Rev    : 1.0 - initial release
//============================================================================
module umi_arb_tagfifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW         = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  // Entry storage; only occupied slots are ever read, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; push while full is legal only alongside a pop
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == FULL_COUNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/umi_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module : umi_mem_arbiter
// Desc   : Round-robin arbiter sharing one UMI memory agent among N
//          requesters, with per-message grant locking and tag-FIFO steering
//          of in-order responses back to the originating requester.
// Rev    : 1.0 - initial release
//============================================================================
module umi_mem_arbiter
  import umi_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*CW-1:0] req_cmd,
  input  logic [N*AW-1:0] req_dstaddr,
  input  logic [N*AW-1:0] req_srcaddr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    resp_valid,
  output logic [N*CW-1:0] resp_cmd,
  output logic [N*AW-1:0] resp_dstaddr,
  output logic [N*AW-1:0] resp_srcaddr,
  output logic [N*DW-1:0] resp_data,
  input  logic [N-1:0]    resp_ready,
  output logic            mem_req_valid,
  output logic [CW-1:0]   mem_req_cmd,
  output logic [AW-1:0]   mem_req_dstaddr,
  output logic [AW-1:0]   mem_req_srcaddr,
  output logic [DW-1:0]   mem_req_data,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [CW-1:0]   mem_resp_cmd,
  input  logic [AW-1:0]   mem_resp_dstaddr,
  input  logic [AW-1:0]   mem_resp_srcaddr,
  input  logic [DW-1:0]   mem_resp_data,
  output logic            mem_resp_ready,
  output logic            err_orphan
);

  localparam int            IW       = $clog2(N);
  localparam int            CNTW     = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr,   w_ptr_nxt;
  logic          r_err_orphan;

  logic          w_found;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_sel;
  logic [CW-1:0] w_sel_cmd;
  logic          w_sel_rb, w_sel_eom;
  logic          w_grant, w_fire, w_push, w_pop;
  logic [IW-1:0] w_head;
  logic          w_empty, w_full;
  logic [CNTW-1:0] w_count;
  logic          w_unused_ok;

  // Round-robin search: first valid requester at or after ptr, with wrap
  always_comb begin : p_search
    logic [IW-1:0] idx;
    w_found = 1'b0;
    w_cand  = r_ptr;
    idx     = r_ptr;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(r_ptr) + k) % N);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_cand  = idx;
      end
    end
  end

  // Select the owner while locked, otherwise the search winner; a response-
  // bearing head is held back only if the tag FIFO stays full this cycle
  assign w_sel     = (r_state == ARB_LOCKED) ? r_owner : w_cand;
  assign w_sel_cmd = req_cmd[w_sel*CW +: CW];
  assign w_sel_rb  = umi_is_rb(w_sel_cmd[UMI_OPCODE_LSB +: UMI_OPCODE_W]);
  assign w_sel_eom = w_sel_cmd[UMI_EOM_BIT];
  assign w_grant   = (r_state == ARB_LOCKED) ? 1'b1
                   : (w_found & ~(w_sel_rb & w_full & ~w_pop));

  assign mem_req_valid   = w_grant & req_valid[w_sel];
  assign mem_req_cmd     = w_sel_cmd;
  assign mem_req_dstaddr = req_dstaddr[w_sel*AW +: AW];
  assign mem_req_srcaddr = req_srcaddr[w_sel*AW +: AW];
  assign mem_req_data    = req_data[w_sel*DW +: DW];

  assign w_fire = mem_req_valid & mem_req_ready;
  assign w_push = w_fire & (r_state == ARB_IDLE) & w_sel_rb;

  // Message lock state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Lock on a non-final first beat; release and advance ptr on the EOM beat
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_fire) begin
          if (w_sel_eom) begin
            w_ptr_nxt = (w_sel == LAST_IDX) ? '0 : w_sel + IW'(1);
          end else begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_sel;
          end
        end
      end
      ARB_LOCKED: begin
        if (w_fire && w_sel_eom) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = (r_owner == LAST_IDX) ? '0 : r_owner + IW'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  umi_arb_tagfifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_tagfifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (w_push),
    .push_data (w_sel),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Occupancy is exported by the FIFO for observability; the arbiter only needs full/empty
  assign w_unused_ok = &{1'b0, w_count};

  // With no tag outstanding the response is an orphan and is drained
  assign mem_resp_ready = w_empty ? mem_resp_valid : resp_ready[w_head];
  assign w_pop          = mem_resp_valid & mem_resp_ready & ~w_empty
                        & mem_resp_cmd[UMI_EOM_BIT];

  generate
    for (genvar i = 0; i < N; i++) begin : g_port
      assign req_ready[i]               = mem_req_ready & w_grant & (w_sel == IW'(i));
      assign resp_valid[i]              = mem_resp_valid & ~w_empty & (w_head == IW'(i));
      assign resp_cmd[i*CW +: CW]       = mem_resp_cmd;
      assign resp_dstaddr[i*AW +: AW]   = mem_resp_dstaddr;
      assign resp_srcaddr[i*AW +: AW]   = mem_resp_srcaddr;
      assign resp_data[i*DW +: DW]      = mem_resp_data;
    end
  endgenerate

  // Sticky flag for a response that arrives with no tag to steer it
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                       r_err_orphan <= 1'b0;
    else if (mem_resp_valid && w_empty) r_err_orphan <= 1'b1;
  end

  assign err_orphan = r_err_orphan;

endmodule
`default_nettype wire

// File: doc/umi_mem_arbiter.md
# umi_mem_arbiter

Round-robin arbiter that shares one UMI memory agent device port among N UMI requesters. Sits directly in front of the memory agent. Request messages are forwarded unmodified with per-message grant locking. Responses from the in-order agent are steered back to the originating requester through an internal tag FIFO.

## Interface
Parameters:
- N, 4, number of requester ports (2..16)
- DW, 256, UMI data width
- AW, 64, address width
- CW, 32, command width
- DEPTH, 8, max outstanding response-bearing messages (power of 2)

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- req_valid  in  N  per-requester request valid
- req_cmd  in  N*CW  request cmd, requester i at [i*CW+:CW]
- req_dstaddr  in  N*AW  request dstaddr
- req_srcaddr  in  N*AW  request srcaddr
- req_data  in  N*DW  request data
- req_ready  out  N  request ready
- resp_valid  out  N  response valid
- resp_cmd  out  N*CW  response cmd (broadcast)
- resp_dstaddr  out  N*AW  response dstaddr (broadcast)
- resp_srcaddr  out  N*AW  response srcaddr (broadcast)
- resp_data  out  N*DW  response data (broadcast)
- resp_ready  in  N  response ready
- mem_req_valid, mem_req_cmd, mem_req_dstaddr, mem_req_srcaddr, mem_req_data  out  1/CW/AW/AW/DW  request to memory agent
- mem_req_ready  in  1
- mem_resp_valid, mem_resp_cmd, mem_resp_dstaddr, mem_resp_srcaddr, mem_resp_data  in  1/CW/AW/AW/DW  response from memory agent
- mem_resp_ready  out  1
- err_orphan  out  1  sticky: response arrived with tag FIFO empty

## Operation
- Decode: EOM = cmd[22]. opcode = cmd[4:0]. Response-bearing (RB) opcodes: 0x01 read, 0x03 write, 0x09 atomic. All others, including 0x05 posted, produce no tag.
- Arbiter state: `lock` (1b), `owner` (log2 N), `ptr` (log2 N).
- IDLE (lock=0):
  - Grant the first requester with req_valid set, searching from ptr upward with wrap.
  - If that requester's cmd is RB and the tag FIFO is full, grant nobody that cycle.
  - Posted/non-RB requests are never blocked by a full FIFO.
- A beat accepted in IDLE is the first beat of a message.
  - If RB, push the granted index into the tag FIFO on the same edge.
  - If EOM=0, enter LOCKED with owner = granted index.
  - If EOM=1, stay IDLE and set ptr = granted+1 mod N.
- LOCKED: only owner is muxed to mem_req. On the accepted beat with EOM=1: lock←0, ptr←owner+1 mod N. No tag push in LOCKED.
- req_ready[i] = mem_req_ready & (i is granted/owner). mem_req_* = mux of the selected requester. mem_req_valid=0 when there is no grant.
- Response path, head = tag FIFO head:
  - resp_valid[i] = mem_resp_valid & ~empty & head==i.
  - mem_resp_ready = ~empty & resp_ready[head].
  - resp_* payload is broadcast to all ports.
  - Pop the FIFO on a handshake whose mem_resp_cmd EOM=1. Split responses with EOM=0 do not pop.
- Orphan response (mem_resp_valid & empty): mem_resp_ready=1 to drain it; err_orphan←1 until reset.
- Tag FIFO:
  - Count width log2(DEPTH)+1.
  - Push and pop in the same cycle are allowed, including when full: the grant check uses full & ~pop.
  - Pointers wrap mod DEPTH.

## Timing
- Request path: zero-cycle combinational mux, no added latency. Response path: zero-cycle combinational.
- Tag push and pop take effect at the posedge of the qualifying handshake. A tag pushed at edge k can route a response at cycle k+1 or later.
- Reset values: lock=0, ptr=0, owner=0, FIFO empty, err_orphan=0. As a result, all resp_valid=0 and mem_resp_ready=0 at reset.
- Reset mid-message drops the lock and all outstanding tags. The memory agent must be reset together with this block.
- req_valid must stay asserted with stable payload until ready, per UMI rules. The arbiter never revokes a grant within a cycle, and never switches owner while locked.

## Structure
- Shared package umi_pkg holds: UMI opcode constants (REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, REQ_ATOMIC=0x09), EOM bit index 22, opcode field [4:0].
- One sub-module: umi_arb_tagfifo, a synchronous FIFO of width log2(N) and depth DEPTH with full, empty and count outputs.
- Arbitration and muxing stay in the top module.

## Test plan
- N=4, DEPTH=8. Requesters 0–3 each issue one read (cmd opcode 0x01, EOM=1) in the same cycle, mem_req_ready=1. Required: grants in order 0,1,2,3 on consecutive cycles; responses return to ports 0,1,2,3 in order; err_orphan=0.
- Requester 1 sends a 3-beat write (EOM 0,0,1) while requester 2 holds req_valid. Required: 2 is not granted until the cycle after 1's EOM beat; exactly one tag (1) is pushed.
- 8 reads from requester 0 with responses stalled (mem_resp_valid=0). Required: a 9th read stalls (req_ready=0). A posted write (0x05) from requester 3 is still granted. The read proceeds in the cycle the first response pops.
- Split response: one read answered by 2 response beats (EOM 0 then 1) while resp_ready toggles 1,0,1. Required: both beats go to the origin port, one pop only on the EOM beat.
- mem_resp_valid=1 with FIFO empty. Required: mem_resp_ready=1, all resp_valid=0, err_orphan=1 next cycle and held until nreset.
- Assert nreset while locked with 3 tags outstanding. Required: all resp_valid=0 and err_orphan=0 while reset is asserted; ptr=0 afterwards.
